// File: rtl/hum_frame_validator.sv
// hum_frame_validator
//   Validates raw 40-bit DHT22 frames {hum[15:0], temp[15:0] sign-magnitude, chk[7:0]},
//   holds the last good frame, converts temperature to two's complement, flags stale
//   data and keeps saturating diagnostic counters.
//
// Ports
//   clk1M        1 MHz clock, rising edge
//   rst_n        asynchronous active-low reset
//   frame_in     raw frame, stable while frame_stb=1
//   frame_stb    one-cycle pulse, frame_in complete
//   hold_frame   last frame that passed all checks
//   hum_x10      humidity of hold_frame, unsigned x10 %RH
//   temp_x10     temperature of hold_frame, two's complement x10 degC
//   data_valid   at least one commit since reset
//   stale        no commit yet, or none for STALE_CYCLES cycles
//   new_stb      one-cycle pulse per commit
//   chk_err_cnt  saturating checksum-failure count
//   rng_err_cnt  saturating range / all-zero reject count
//   ovr_cnt      saturating count of strobes dropped while busy
//
// state   | meaning
// IDLE    | waiting for frame_stb
// CAPTURE | frame latched, computing checksum and temperature fields
// CHECK   | checksum, all-zero and range tests
// COMMIT  | frame accepted, outputs load on the edge leaving this state
// REJECT  | frame discarded, outputs unchanged
module hum_frame_validator #(
  parameter int STALE_CYCLES = 12_000_000,
  parameter int HUM_MAX      = 1000,
  parameter int TEMP_MIN     = -400,
  parameter int TEMP_MAX     = 800
) (
  input  logic        clk1M,
  input  logic        rst_n,
  input  logic [39:0] frame_in,
  input  logic        frame_stb,
  output logic [39:0] hold_frame,
  output logic [15:0] hum_x10,
  output logic [15:0] temp_x10,
  output logic        data_valid,
  output logic        stale,
  output logic        new_stb,
  output logic [7:0]  chk_err_cnt,
  output logic [7:0]  rng_err_cnt,
  output logic [7:0]  ovr_cnt
);

  localparam logic [23:0]        STALE_LIM = 24'(STALE_CYCLES);
  localparam logic [15:0]        HUM_LIM   = 16'(HUM_MAX);
  localparam logic signed [16:0] T_MIN     = 17'(TEMP_MIN);
  localparam logic signed [16:0] T_MAX     = 17'(TEMP_MAX);

  typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, COMMIT, REJECT} state_t;

  state_t             state, state_nxt;
  logic [39:0]        f;
  logic [7:0]         sum8;
  logic [14:0]        tmag;
  logic               tsgn;
  logic [23:0]        stale_tmr;
  logic signed [16:0] temp_s;
  logic               chk_bad, rng_bad;
  logic               latch_en, commit_en, chk_inc, rng_inc, ovr_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign temp_s  = tsgn ? -$signed({2'b00, tmag}) : $signed({2'b00, tmag});
  assign chk_bad = (sum8 != f[7:0]);
  // The all-zero frame has a valid checksum, so it is caught here instead.
  assign rng_bad = (f[39:8] == 32'd0) || (f[39:24] > HUM_LIM) ||
                   (temp_s < T_MIN) || (temp_s > T_MAX);

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_stb) state_nxt = CAPTURE;
      CAPTURE: state_nxt = CHECK;
      CHECK:   state_nxt = (chk_bad || rng_bad) ? REJECT : COMMIT;
      COMMIT:  state_nxt = IDLE;
      REJECT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    latch_en  = (state == IDLE) && frame_stb;
    ovr_inc   = (state != IDLE) && frame_stb;
    chk_inc   = (state == CHECK) && chk_bad;
    rng_inc   = (state == CHECK) && !chk_bad && rng_bad;
    commit_en = (state == COMMIT);
  end

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      f    <= '0;
      sum8 <= '0;
      tmag <= '0;
      tsgn <= 1'b0;
    end else begin
      if (latch_en) f <= frame_in;
      if (state == CAPTURE) begin
        sum8 <= f[39:32] + f[31:24] + f[23:16] + f[15:8];
        tmag <= f[22:8];
        tsgn <= f[23];
      end
    end
  end

  // Outputs load on the edge leaving COMMIT, so new_stb and the data appear together.
  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      hold_frame <= '0;
      hum_x10    <= '0;
      temp_x10   <= '0;
      data_valid <= 1'b0;
      new_stb    <= 1'b0;
    end else begin
      new_stb <= commit_en;
      if (commit_en) begin
        hold_frame <= f;
        hum_x10    <= f[39:24];
        temp_x10   <= tsgn ? (16'd0 - {1'b0, tmag}) : {1'b0, tmag};
        data_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_cnt <= '0;
      rng_err_cnt <= '0;
      ovr_cnt     <= '0;
    end else begin
      if (chk_inc) chk_err_cnt <= sat_inc(chk_err_cnt);
      if (rng_inc) rng_err_cnt <= sat_inc(rng_err_cnt);
      if (ovr_inc) ovr_cnt     <= sat_inc(ovr_cnt);
    end
  end

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n)                      stale_tmr <= '0;
    else if (commit_en)              stale_tmr <= '0;
    else if (stale_tmr != STALE_LIM) stale_tmr <= stale_tmr + 24'd1;
  end

  assign stale = !data_valid || (stale_tmr == STALE_LIM);

endmodule

// File: tb/tb_hum_frame_validator.sv
module tb_hum_frame_validator;

  localparam int STALE = 100;

  logic        clk1M = 1'b0;
  logic        rst_n;
  logic [39:0] frame_in;
  logic        frame_stb;
  logic [39:0] hold_frame;
  logic [15:0] hum_x10, temp_x10;
  logic        data_valid, stale, new_stb;
  logic [7:0]  chk_err_cnt, rng_err_cnt, ovr_cnt;

  hum_frame_validator #(.STALE_CYCLES(STALE)) dut (
    .clk1M(clk1M), .rst_n(rst_n), .frame_in(frame_in), .frame_stb(frame_stb),
    .hold_frame(hold_frame), .hum_x10(hum_x10), .temp_x10(temp_x10),
    .data_valid(data_valid), .stale(stale), .new_stb(new_stb),
    .chk_err_cnt(chk_err_cnt), .rng_err_cnt(rng_err_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 clk1M = ~clk1M;

  int unsigned cyc = 0;
  always @(posedge clk1M) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // reference state
  logic [39:0] m_hold;
  logic [15:0] m_hum, m_temp;
  logic        m_valid;
  int          m_chk, m_rng, m_ovr;
  int unsigned last_commit;

  typedef struct {
    logic [39:0] frame;
    int          cls;    // 0 commit, 1 checksum error, 2 range/zero error
    logic [15:0] hum;    // expected hum_x10 afterwards
    logic [15:0] temp;   // expected temp_x10 afterwards
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  function automatic int classify(input logic [39:0] fr);
    int s, hum, mag, t;
    s   = (int'(fr[39:32]) + int'(fr[31:24]) + int'(fr[23:16]) + int'(fr[15:8])) % 256;
    hum = int'(fr[39:24]);
    mag = int'(fr[22:8]);
    t   = fr[23] ? -mag : mag;
    if (s != int'(fr[7:0])) return 1;
    if (fr[39:8] == 32'd0) return 2;
    if (hum > 1000 || t < -400 || t > 800) return 2;
    return 0;
  endfunction

  function automatic logic [15:0] ref_temp(input logic [39:0] fr);
    int mag, t;
    mag = int'(fr[22:8]);
    t   = fr[23] ? -mag : mag;
    return 16'(t);
  endfunction

  task automatic model_reset();
    m_hold = '0; m_hum = '0; m_temp = '0; m_valid = 1'b0;
    m_chk = 0; m_rng = 0; m_ovr = 0; last_commit = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic exp_stale;
    exp_stale = !m_valid || ((cyc - last_commit) >= STALE);
    check({tag, " hold_frame"}, hold_frame, m_hold);
    check({tag, " hum_x10"}, {24'd0, hum_x10}, {24'd0, m_hum});
    check({tag, " temp_x10"}, {24'd0, temp_x10}, {24'd0, m_temp});
    check({tag, " data_valid"}, {39'd0, data_valid}, {39'd0, m_valid});
    check({tag, " stale"}, {39'd0, stale}, {39'd0, exp_stale});
    check({tag, " chk_err_cnt"}, {32'd0, chk_err_cnt}, 40'(m_chk));
    check({tag, " rng_err_cnt"}, {32'd0, rng_err_cnt}, 40'(m_rng));
    check({tag, " ovr_cnt"}, {32'd0, ovr_cnt}, 40'(m_ovr));
  endtask

  // Strobe one frame, confirm new_stb timing, then compare all outputs.
  task automatic apply_frame(input string tag, input logic [39:0] fr, input int cls,
                             input logic [15:0] ehum, input logic [15:0] etemp);
    @(negedge clk1M); frame_in = fr; frame_stb = 1'b1;
    @(negedge clk1M); frame_stb = 1'b0;
    @(negedge clk1M);
    check({tag, " new_stb early1"}, {39'd0, new_stb}, 40'd0);
    @(negedge clk1M);
    check({tag, " new_stb early2"}, {39'd0, new_stb}, 40'd0);
    @(negedge clk1M);
    check({tag, " new_stb"}, {39'd0, new_stb}, {39'd0, (cls == 0)});
    if (cls == 0) begin
      m_hold = fr; m_valid = 1'b1; last_commit = cyc;
    end else if (cls == 1) m_chk = sat(m_chk);
    else m_rng = sat(m_rng);
    m_hum = ehum; m_temp = etemp;
    check_outputs(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [39:0] fr;
    logic [15:0] rh, rt;
    logic [7:0]  ck;
    int          c, hum, mag;
    logic        seen;

    vecs[0]  = '{40'h0292_010D_A2, 0, 16'd658,  16'h010D};
    vecs[1]  = '{40'h0292_8065_79, 0, 16'd658,  16'hFF9B};
    vecs[2]  = '{40'h0292_010D_A3, 1, 16'd658,  16'hFF9B};
    vecs[3]  = '{40'h0000_0000_00, 2, 16'd658,  16'hFF9B};
    vecs[4]  = '{40'h03E9_010D_FA, 2, 16'd658,  16'hFF9B};
    vecs[5]  = '{40'h0292_8191_A6, 2, 16'd658,  16'hFF9B};
    vecs[6]  = '{40'h0292_0321_B8, 2, 16'd658,  16'hFF9B};
    vecs[7]  = '{40'h03E9_010D_00, 1, 16'd658,  16'hFF9B};
    vecs[8]  = '{40'h0292_8000_14, 0, 16'd658,  16'h0000};
    vecs[9]  = '{40'h03E8_0320_0E, 0, 16'd1000, 16'h0320};
    vecs[10] = '{40'h0292_8190_A5, 0, 16'd658,  16'hFE70};

    rst_n = 1'b0; frame_in = '0; frame_stb = 1'b0;
    model_reset();
    repeat (3) @(negedge clk1M);
    check_outputs("reset");
    check("reset new_stb", {39'd0, new_stb}, 40'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      apply_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].cls, vecs[i].hum, vecs[i].temp);

    // stale after exactly STALE idle cycles, hold_frame kept
    repeat (STALE - 1) @(negedge clk1M);
    check("stale before limit", {39'd0, stale}, 40'd0);
    @(negedge clk1M);
    check("stale at limit", {39'd0, stale}, 40'd1);
    check("stale hold_frame", hold_frame, 40'h0292_8190_A5);
    apply_frame("stale recover", 40'h0292_010D_A2, 0, 16'd658, 16'h010D);
    check("stale cleared", {39'd0, stale}, 40'd0);

    // randomized frames against the reference model
    for (int i = 0; i < 80; i++) begin
      hum = int'($urandom_range(0, 1100));
      mag = int'($urandom_range(0, 900));
      fr  = {16'(hum), 1'($urandom_range(0, 1)), 15'(mag), 8'd0};
      ck  = 8'((int'(fr[39:32]) + int'(fr[31:24]) + int'(fr[23:16]) + int'(fr[15:8])) % 256);
      if ($urandom_range(0, 5) == 0) ck = ck ^ (8'd1 << $urandom_range(0, 7));
      fr[7:0] = ck;
      if ($urandom_range(0, 19) == 0) fr = '0;
      c  = classify(fr);
      rh = (c == 0) ? fr[39:24] : m_hum;
      rt = (c == 0) ? ref_temp(fr) : m_temp;
      apply_frame($sformatf("rand%0d", i), fr, c, rh, rt);
    end

    // overrun: second strobe while busy is dropped, first frame commits
    @(negedge clk1M); frame_in = 40'h0292_010D_A2; frame_stb = 1'b1;
    @(negedge clk1M); frame_in = 40'h1111_1111_11;
    @(negedge clk1M); frame_stb = 1'b0;
    @(negedge clk1M);
    check("ovr new_stb early", {39'd0, new_stb}, 40'd0);
    @(negedge clk1M);
    check("ovr new_stb", {39'd0, new_stb}, 40'd1);
    m_ovr = sat(m_ovr); m_hold = 40'h0292_010D_A2; m_valid = 1'b1; last_commit = cyc;
    m_hum = 16'd658; m_temp = 16'h010D;
    check_outputs("ovr");

    // reset mid-frame discards it
    @(negedge clk1M); frame_in = 40'h0292_8065_79; frame_stb = 1'b1;
    @(negedge clk1M); frame_stb = 1'b0;
    @(negedge clk1M); rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    check("midreset new_stb", {39'd0, new_stb}, 40'd0);
    repeat (2) @(negedge clk1M);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk1M);
      if (new_stb) seen = 1'b1;
    end
    check("midreset no new_stb", {39'd0, seen}, 40'd0);
    check_outputs("postreset");

    // checksum counter saturation
    for (int i = 0; i < 300; i++) begin
      @(negedge clk1M); frame_in = 40'h0292_010D_A3; frame_stb = 1'b1;
      @(negedge clk1M); frame_stb = 1'b0;
      repeat (3) @(negedge clk1M);
    end
    m_chk = 255;
    check_outputs("chk sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
